// File: rtl/semaforo_monitor.sv
// Passive checker for the A/B traffic-light buses: phase tracking, duration and error flags.
// Latency: 1 cycle from sample to every output. Never drives the lights and applies no backpressure.
module semaforo_monitor #(
    parameter int G_MIN = 8,
    parameter int Y_LEN = 3,
    parameter int R_MIN = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       a,
    input  logic [2:0]       b,
    input  logic             clr,
    output logic [1:0]       phase_a,
    output logic [CNT_W-1:0] dur_a,
    output logic             walk,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_timing,
    output logic             err_conflict,
    output logic [3:0]       err_sticky
);

    typedef enum logic [1:0] {
        PH_UNK = 2'd0,
        PH_R   = 2'd1,
        PH_Y   = 2'd2,
        PH_G   = 2'd3
    } phase_t;

    localparam logic [CNT_W-1:0] DUR_MAX = '1;
    localparam logic [CNT_W-1:0] G_MIN_C = CNT_W'(G_MIN);
    localparam logic [CNT_W-1:0] Y_LEN_C = CNT_W'(Y_LEN);
    localparam logic [CNT_W-1:0] R_MIN_C = CNT_W'(R_MIN);

    function automatic phase_t f_decode(input logic [2:0] v);
        case (v)
            3'b001:  return PH_R;
            3'b010:  return PH_Y;
            3'b100:  return PH_G;
            default: return PH_UNK;
        endcase
    endfunction

    function automatic logic f_legal(input phase_t from, input phase_t to);
        return ((from == PH_G) && (to == PH_Y)) ||
               ((from == PH_Y) && (to == PH_R)) ||
               ((from == PH_R) && (to == PH_G));
    endfunction

    function automatic logic f_dur_ok(input phase_t ph, input logic [CNT_W-1:0] d);
        case (ph)
            PH_G:    return d >= G_MIN_C;
            PH_Y:    return d == Y_LEN_C;
            PH_R:    return d >= R_MIN_C;
            default: return 1'b1;
        endcase
    endfunction

    phase_t           r_ph_a;
    phase_t           r_ph_b;
    logic [CNT_W-1:0] r_dur_a;
    logic             r_first_a;
    logic             r_walk;
    logic             r_err_onehot;
    logic             r_err_seq;
    logic             r_err_timing;
    logic             r_err_conflict;
    logic [3:0]       r_sticky;

    phase_t w_code_a;
    phase_t w_code_b;
    logic   w_valid;
    logic   w_chg_a;
    logic   w_chg_b;
    logic   w_bad;
    logic   w_seq;
    logic   w_tim;
    logic   w_conf;

    assign w_code_a = f_decode(a);
    assign w_code_b = f_decode(b);
    assign w_valid  = (w_code_a != PH_UNK) && (w_code_b != PH_UNK);
    assign w_bad    = !w_valid;
    assign w_chg_a  = w_valid && (r_ph_a != PH_UNK) && (w_code_a != r_ph_a);
    assign w_chg_b  = w_valid && (r_ph_b != PH_UNK) && (w_code_b != r_ph_b);
    assign w_seq    = (w_chg_a && !f_legal(r_ph_a, w_code_a)) ||
                      (w_chg_b && !f_legal(r_ph_b, w_code_b));
    // The phase loaded straight from "unknown" may be truncated, so its length is not judged.
    assign w_tim    = w_chg_a && !r_first_a && !f_dur_ok(r_ph_a, r_dur_a);
    assign w_conf   = w_valid &&
                      (((w_code_b == PH_Y) && (w_code_a != PH_Y)) ||
                       ((w_code_b == PH_R) && (w_code_a == PH_G)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ph_a         <= PH_UNK;
            r_ph_b         <= PH_UNK;
            r_dur_a        <= '0;
            r_first_a      <= 1'b0;
            r_walk         <= 1'b0;
            r_err_onehot   <= 1'b0;
            r_err_seq      <= 1'b0;
            r_err_timing   <= 1'b0;
            r_err_conflict <= 1'b0;
            r_sticky       <= 4'b0;
        end else begin
            r_err_onehot   <= w_bad;
            r_err_seq      <= w_seq;
            r_err_timing   <= w_tim;
            r_err_conflict <= w_conf;
            r_sticky       <= (clr ? 4'b0 : r_sticky) | {w_conf, w_tim, w_seq, w_bad};
            if (w_valid) begin
                if (r_ph_a == PH_UNK) begin
                    r_ph_a    <= w_code_a;
                    r_dur_a   <= CNT_W'(1);
                    r_first_a <= 1'b1;
                end else if (w_code_a == r_ph_a) begin
                    if (r_dur_a != DUR_MAX) begin
                        r_dur_a <= r_dur_a + 1'b1;
                    end
                end else begin
                    r_ph_a    <= w_code_a;
                    r_dur_a   <= CNT_W'(1);
                    r_first_a <= 1'b0;
                end
                r_ph_b <= w_code_b;
                r_walk <= (w_code_b == PH_R);
            end
        end
    end

    assign phase_a      = r_ph_a;
    assign dur_a        = r_dur_a;
    assign walk         = r_walk;
    assign err_onehot   = r_err_onehot;
    assign err_seq      = r_err_seq;
    assign err_timing   = r_err_timing;
    assign err_conflict = r_err_conflict;
    assign err_sticky   = r_sticky;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Bench for semaforo_monitor: run-length reference model compared every cycle, directed plus random traffic.
module tb_semaforo_monitor;

    localparam int G_MIN = 8;
    localparam int Y_LEN = 3;
    localparam int R_MIN = 5;
    localparam int CNT_W = 8;
    localparam int DMAX  = (1 << CNT_W) - 1;

    localparam logic [2:0] LR = 3'b001;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b100;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       a = 3'b0;
    logic [2:0]       b = 3'b0;
    logic             clr = 1'b0;
    logic [1:0]       phase_a;
    logic [CNT_W-1:0] dur_a;
    logic             walk;
    logic             err_onehot;
    logic             err_seq;
    logic             err_timing;
    logic             err_conflict;
    logic [3:0]       err_sticky;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: A history as runs of identical valid samples, B as its last valid light.
    logic [2:0] run_ph[$];
    int         run_len[$];
    logic [2:0] m_b;
    int         m_phase;
    int         m_dur;
    logic       m_walk;
    logic       m_oh;
    logic       m_seq;
    logic       m_tim;
    logic       m_conf;
    logic [3:0] m_sticky;

    logic [2:0] ra = LG;
    logic [2:0] rb = LG;

    always #5 clk = ~clk;

    semaforo_monitor #(
        .G_MIN(G_MIN),
        .Y_LEN(Y_LEN),
        .R_MIN(R_MIN),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .clr(clr),
        .phase_a(phase_a),
        .dur_a(dur_a),
        .walk(walk),
        .err_onehot(err_onehot),
        .err_seq(err_seq),
        .err_timing(err_timing),
        .err_conflict(err_conflict),
        .err_sticky(err_sticky)
    );

    function automatic logic [2:0] succ(input logic [2:0] x);
        if (x == LG) return LY;
        if (x == LY) return LR;
        return LG;
    endfunction

    function automatic int code(input logic [2:0] x);
        if (x == LR) return 1;
        if (x == LY) return 2;
        if (x == LG) return 3;
        return 0;
    endfunction

    function automatic int dur_sat(input int n);
        return (n > DMAX) ? DMAX : n;
    endfunction

    function automatic logic dur_ok(input logic [2:0] ph, input int n);
        int d;
        d = dur_sat(n);
        if (ph == LG) return d >= G_MIN;
        if (ph == LY) return d == Y_LEN;
        if (ph == LR) return d >= R_MIN;
        return 1'b1;
    endfunction

    function automatic logic [2:0] rand_light(input logic [2:0] cur);
        int r;
        logic [2:0] c;
        r = $urandom_range(0, 99);
        c = ($countones(cur) == 1) ? cur : LG;
        if (r < 78) return c;
        if (r < 92) return succ(c);
        if (r < 97) begin
            case ($urandom_range(0, 2))
                0:       return LR;
                1:       return LY;
                default: return LG;
            endcase
        end
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic model_reset();
        run_ph.delete();
        run_len.delete();
        m_b      = 3'b0;
        m_phase  = 0;
        m_dur    = 0;
        m_walk   = 1'b0;
        m_oh     = 1'b0;
        m_seq    = 1'b0;
        m_tim    = 1'b0;
        m_conf   = 1'b0;
        m_sticky = 4'b0;
    endtask

    task automatic model_update();
        int last;
        if (!rst) begin
            model_reset();
            return;
        end
        m_oh   = !(($countones(a) == 1) && ($countones(b) == 1));
        m_seq  = 1'b0;
        m_tim  = 1'b0;
        m_conf = 1'b0;
        if (!m_oh) begin
            m_conf = ((b == LY) && (a != LY)) || ((b == LR) && (a == LG));
            last = run_ph.size() - 1;
            if (run_ph.size() == 0) begin
                run_ph.push_back(a);
                run_len.push_back(1);
            end else if (a == run_ph[last]) begin
                run_len[last] = run_len[last] + 1;
            end else begin
                if (a != succ(run_ph[last])) m_seq = 1'b1;
                if ((run_ph.size() > 1) && !dur_ok(run_ph[last], run_len[last])) m_tim = 1'b1;
                run_ph.push_back(a);
                run_len.push_back(1);
                if (run_ph.size() > 4) begin
                    void'(run_ph.pop_front());
                    void'(run_len.pop_front());
                end
            end
            if ((m_b != 3'b0) && (b != m_b) && (b != succ(m_b))) m_seq = 1'b1;
            m_b = b;
        end
        m_sticky = (clr ? 4'b0 : m_sticky) | {m_conf, m_tim, m_seq, m_oh};
        if (run_ph.size() == 0) begin
            m_phase = 0;
            m_dur   = 0;
        end else begin
            m_phase = code(run_ph[run_ph.size() - 1]);
            m_dur   = dur_sat(run_len[run_len.size() - 1]);
        end
        m_walk = (m_b == LR);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic compare_all();
        check("phase_a",      32'(phase_a),      32'(m_phase));
        check("dur_a",        32'(dur_a),        32'(m_dur));
        check("walk",         32'(walk),         32'(m_walk));
        check("err_onehot",   32'(err_onehot),   32'(m_oh));
        check("err_seq",      32'(err_seq),      32'(m_seq));
        check("err_timing",   32'(err_timing),   32'(m_tim));
        check("err_conflict", 32'(err_conflict), 32'(m_conf));
        check("err_sticky",   32'(err_sticky),   32'(m_sticky));
    endtask

    task automatic step(input logic [2:0] na, input logic [2:0] nb, input logic nclr);
        a   = na;
        b   = nb;
        clr = nclr;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_assert();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        a = LG;
        b = LG;
        @(negedge clk);
        compare_all();
        check("rst_phase_a", 32'(phase_a), 0);
        check("rst_dur_a", 32'(dur_a), 0);
        check("rst_sticky", 32'(err_sticky), 0);
        rst = 1'b1;

        // Legal cycle G8 Y3 R5 G, B following A.
        for (int i = 0; i < 8; i++) step(LG, LG, 1'b0);
        check("legal_g_phase", 32'(phase_a), 3);
        check("legal_g_dur", 32'(dur_a), 8);
        for (int i = 0; i < 3; i++) step(LY, LY, 1'b0);
        check("legal_y_phase", 32'(phase_a), 2);
        check("legal_y_dur", 32'(dur_a), 3);
        for (int i = 0; i < 5; i++) step(LR, LR, 1'b0);
        check("legal_r_phase", 32'(phase_a), 1);
        check("legal_r_walk", 32'(walk), 1);
        step(LG, LG, 1'b0);
        check("legal_g2_phase", 32'(phase_a), 3);
        check("legal_g2_walk", 32'(walk), 0);
        check("legal_sticky", 32'(err_sticky), 0);

        // Short green: 5 samples then Y.
        for (int i = 0; i < 4; i++) step(LG, LG, 1'b0);
        step(LY, LY, 1'b0);
        check("short_g_timing", 32'(err_timing), 1);
        check("short_g_sticky", 32'(err_sticky), 32'h4);
        for (int i = 0; i < 2; i++) step(LY, LY, 1'b0);
        for (int i = 0; i < 5; i++) step(LR, LR, 1'b0);
        for (int i = 0; i < 8; i++) step(LG, LG, 1'b0);

        // Skip G->R, then clr alone and clr against a new seq error.
        step(LR, LG, 1'b0);
        check("skip_seq", 32'(err_seq), 1);
        check("skip_phase", 32'(phase_a), 1);
        step(LR, LG, 1'b1);
        check("clr_sticky", 32'(err_sticky), 0);
        step(LY, LG, 1'b1);
        check("clr_set_wins", 32'(err_sticky[1]), 1);

        // Bad encoding holds state, then resumes counting.
        step(LY, LG, 1'b0);
        check("bad_pre_dur", 32'(dur_a), 2);
        for (int i = 0; i < 2; i++) begin
            step(3'b110, LG, 1'b0);
            check("bad_onehot", 32'(err_onehot), 1);
            check("bad_dur_frozen", 32'(dur_a), 2);
            check("bad_phase_frozen", 32'(phase_a), 2);
        end
        step(LY, LG, 1'b0);
        check("bad_resume_dur", 32'(dur_a), 3);
        check("bad_resume_onehot", 32'(err_onehot), 0);

        // Conflicts: B red under A green, B yellow under A red.
        for (int i = 0; i < 3; i++) begin
            step(LG, LR, 1'b0);
            check("conf_g_r", 32'(err_conflict), 1);
        end
        step(LR, LY, 1'b0);
        check("conf_r_y", 32'(err_conflict), 1);
        step(LR, LR, 1'b0);
        check("conf_clear", 32'(err_conflict), 0);

        // Reset mid-yellow, then a long hold saturates dur_a.
        step(LY, LR, 1'b0);
        step(LY, LR, 1'b0);
        check("pre_rst_dur", 32'(dur_a), 2);
        reset_assert();
        check("rst_async_dur", 32'(dur_a), 0);
        check("rst_async_phase", 32'(phase_a), 0);
        check("rst_async_sticky", 32'(err_sticky), 0);
        reset_release();
        step(LG, LG, 1'b0);
        check("post_rst_dur", 32'(dur_a), 1);
        check("post_rst_seq", 32'(err_seq), 0);
        check("post_rst_timing", 32'(err_timing), 0);
        for (int i = 1; i < 300; i++) step(LG, LG, 1'b0);
        check("sat_dur", 32'(dur_a), 255);

        // Random traffic against the model.
        ra = LG;
        rb = LG;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_assert();
                reset_release();
            end
            ra = rand_light(ra);
            rb = ($urandom_range(0, 1) == 0) ? ra : rand_light(rb);
            step(ra, rb, ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
